// File: rtl/bram36_symbol_reader.sv
// Streams DEPTH buffer entries per start through a 3-deep skid FIFO, issuing
// reads only when the FIFO can absorb everything already in flight.
module bram36_symbol_reader #(
  parameter int DEPTH  = 36,
  parameter int DATA_W = 13,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              mem_read_en,
  output logic [ADDR_W-1:0] mem_read_addr,
  input  logic [DATA_W-1:0] mem_read_data,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        occ_q, occ_d;
  logic [1:0]        wr_ptr_q, wr_ptr_d;
  logic [1:0]        rd_ptr_q, rd_ptr_d;
  logic              inflight_q, inflight_d;
  logic              inflight_last_q, inflight_last_d;
  logic              done_q, done_d;
  logic [DATA_W:0]   fifo_q [3];

  logic              issue;
  logic              push;
  logic              pop;
  logic              at_last_addr;
  logic [2:0]        pending;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // A read is only issued if its data is guaranteed a FIFO slot next cycle.
  assign at_last_addr  = (addr_q == ADDR_W'(DEPTH - 1));
  assign pending       = {1'b0, occ_q} + {2'b00, inflight_q};
  assign issue         = (state_q == READ) && (pending < 3'd3);
  assign push          = inflight_q && !abort;
  assign pop           = m_valid && m_ready;

  assign mem_read_en   = issue;
  assign mem_read_addr = addr_q;
  assign m_valid       = (occ_q != 2'd0);
  assign m_data        = m_valid ? fifo_q[rd_ptr_q][DATA_W:1] : '0;
  assign m_last        = m_valid && fifo_q[rd_ptr_q][0];
  assign busy          = (state_q != IDLE) || done_q;
  assign done          = done_q;

  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    occ_d           = occ_q;
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    inflight_d      = issue;
    inflight_last_d = issue && at_last_addr;
    done_d          = 1'b0;

    if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({push, pop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: ;
    endcase

    // done_q blocks a start landing on the done cycle.
    case (state_q)
      IDLE: begin
        if (start && !done_q) begin
          state_d = READ;
          addr_d  = '0;
        end
      end
      READ: begin
        if (issue) begin
          if (at_last_addr) state_d = DRAIN;
          else              addr_d  = addr_q + ADDR_W'(1);
        end
      end
      DRAIN: begin
        if (pop && m_last) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (abort) begin
      state_d         = IDLE;
      occ_d           = 2'd0;
      wr_ptr_d        = 2'd0;
      rd_ptr_d        = 2'd0;
      inflight_d      = 1'b0;
      inflight_last_d = 1'b0;
      done_d          = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      addr_q          <= '0;
      occ_q           <= 2'd0;
      wr_ptr_q        <= 2'd0;
      rd_ptr_q        <= 2'd0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      occ_q           <= occ_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      done_q          <= done_d;
    end
  end

  // Storage needs no reset: occupancy gates visibility of every entry.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= {mem_read_data, inflight_last_q};
  end

endmodule

// File: doc/bram36_symbol_reader.md
BRAM36_SYMBOL_READER -- requirements
Module: bram36_symbol_reader

Interface
REQ-001 Parameters SHALL be: DEPTH, default 36, number of entries per symbol; DATA_W, default 13, sample width; ADDR_W, default 6, address width.
REQ-002 clk  input  1  sole clock; all state SHALL change on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  single-cycle request to read entries 0..DEPTH-1.
REQ-005 abort  input  1  synchronous flush of an in-progress read.
REQ-006 busy  output  1  high from the cycle after an accepted start until the end of the done or abort cycle.
REQ-007 done  output  1  one-cycle pulse after the last sample is accepted.
REQ-008 mem_read_en  output  1  buffer read strobe.
REQ-009 mem_read_addr  output  ADDR_W  buffer read address.
REQ-010 mem_read_data  input  DATA_W  buffer read data: valid the cycle after mem_read_en; zero otherwise.
REQ-011 m_data  output  DATA_W  output sample.
REQ-012 m_valid  output  1  m_data valid.
REQ-013 m_ready  input  1  downstream accepts; transfer = m_valid && m_ready.
REQ-014 m_last  output  1  marks the sample from address DEPTH-1.

Function
REQ-015 States SHALL be IDLE, READ, DRAIN.
- IDLE->READ on start.
- READ->DRAIN after the read of address DEPTH-1 is issued.
- DRAIN->IDLE on transfer with m_last=1.
- Any state->IDLE on abort.
REQ-016 start SHALL be ignored unless the state is IDLE.
REQ-017 A 3-entry output FIFO SHALL hold {data, last}; occ SHALL be the FIFO occupancy (0..3) and inflight SHALL be 1 when a read was issued the previous cycle.
REQ-018 mem_read_en SHALL be combinational = (state==READ) && (occ+inflight < 3); it SHALL NOT depend on m_ready.
REQ-019 mem_read_addr SHALL start at 0 on entry to READ, increment by 1 after each issued read, and stop at DEPTH-1 (no wrap).
REQ-020 mem_read_data SHALL be pushed into the FIFO in the cycle after each issued read, with last=1 for address DEPTH-1.
REQ-021 m_valid SHALL equal (occ>0); m_data and m_last SHALL reflect the FIFO head.
REQ-022 m_data and m_last SHALL hold stable while m_valid && !m_ready.
REQ-023 Latency: with start sampled at edge t, the first read SHALL issue in cycle t+1, and m_valid SHALL rise in cycle t+3.
REQ-024 Throughput: with m_ready held high, the block SHALL deliver DEPTH samples on consecutive cycles, with done one cycle after the last transfer.
REQ-025 A push and a pop in the same cycle SHALL leave occ unchanged; the FIFO SHALL never overflow or underflow.
REQ-026 Exactly DEPTH transfers SHALL occur per symbol, in address order, with no duplicates or drops under arbitrary m_ready.
REQ-027 On abort: clear FIFO and inflight, set mem_read_en=0, return to IDLE next edge, and suppress done; abort SHALL take precedence over start in the same cycle.
REQ-028 Read data returning in the cycle after abort SHALL be discarded.
REQ-029 A start in the same cycle as done SHALL be ignored; the next start is accepted from IDLE.

Reset
REQ-030 While rst=1, at all times: state=IDLE, mem_read_addr=0, occ=0, inflight=0.
REQ-031 While rst=1, outputs SHALL read: busy=0, done=0, mem_read_en=0, m_valid=0, m_data=0, m_last=0.
REQ-032 Reset asserted mid-symbol SHALL discard all progress; after release the block SHALL wait for a new start.

Verification
REQ-033 Buffer preloaded with value = 100+addr, m_ready=1, start at cycle 0 -> m_valid from cycle 3; samples 100..135 on consecutive cycles; m_last with 135; done one cycle later.
REQ-034 m_ready=0 after start -> exactly 3 reads issued (addr 0,1,2); m_data=100 held; mem_read_en=0 until m_ready rises; full sequence then completes intact.
REQ-035 Random m_ready (50%) -> exactly 36 transfers, in order, one m_last, one done; occ never exceeds 3.
REQ-036 abort at cycle 10 -> mem_read_en=0, m_valid=0, busy=0 next cycle; no done; a subsequent start yields the full 100..135.
REQ-037 rst pulsed mid-symbol, then start -> all outputs zero during reset; after start, the first sample is 100.
REQ-038 start re-pulsed while busy, and start coincident with done -> both ignored; one symbol per accepted start.
